// File: rtl/mdu_unit.sv
// Multiply/divide unit holding the architectural HI/LO registers, with a fixed-latency Busy window.
// Optional MDU_MADD_EN enables madd/maddu/msub/msubu (codes 7-10); without it those codes are no-ops.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] In0,
    input  logic [31:0] In1,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   ph_q, ph_d, pl_q, pl_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          busy_q, busy_d;

    logic [63:0]   prod_s, prod_u;
    logic [31:0]   sq, sr, uq, ur;
    logic          div_zero, div_ovf;

    assign prod_s   = $signed({{32{In0[31]}}, In0}) * $signed({{32{In1[31]}}, In1});
    assign prod_u   = {32'd0, In0} * {32'd0, In1};
    assign div_zero = (In1 == 32'd0);
    assign div_ovf  = (In0 == 32'h8000_0000) && (In1 == 32'hFFFF_FFFF);

    // Guard the two cases where native division is undefined or overflows.
    always_comb begin
        sq = 32'd0;
        sr = 32'd0;
        uq = 32'd0;
        ur = 32'd0;
        if (!div_zero) begin
            uq = In0 / In1;
            ur = In0 % In1;
            if (div_ovf) begin
                sq = 32'h8000_0000;
            end else begin
                sq = $signed(In0) / $signed(In1);
                sr = $signed(In0) % $signed(In1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (MDOp)
                        4'd1, 4'd2: begin
                            {ph_d, pl_d} = (MDOp == 4'd1) ? prod_s : prod_u;
                            cnt_d   = CW'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        4'd3, 4'd4: begin
                            // Divide by zero commits the current HI/LO back unchanged.
                            if (div_zero)          {ph_d, pl_d} = {hi_q, lo_q};
                            else if (MDOp == 4'd3) {ph_d, pl_d} = {sr, sq};
                            else                   {ph_d, pl_d} = {ur, uq};
                            cnt_d   = CW'(DIV_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        4'd5: hi_d = In0;
                        4'd6: lo_d = In0;
`ifdef MDU_MADD_EN
                        4'd7, 4'd8, 4'd9, 4'd10: begin
                            case (MDOp)
                                4'd7:    {ph_d, pl_d} = {hi_q, lo_q} + prod_s;
                                4'd8:    {ph_d, pl_d} = {hi_q, lo_q} + prod_u;
                                4'd9:    {ph_d, pl_d} = {hi_q, lo_q} - prod_s;
                                default: {ph_d, pl_d} = {hi_q, lo_q} - prod_u;
                            endcase
                            cnt_d   = CW'(MULT_CYCLES);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = ph_q;
                    lo_d    = pl_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: a cycle-level behavioural model of HI/LO/Busy plus literal checks.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  MDOp = 4'd0;
    logic [31:0] In0 = 32'd0;
    logic [31:0] In1 = 32'd0;
    logic        Busy;
    logic [31:0] HI, LO;

    int tests = 0;
    int fails = 0;
    int ill_cnt = 0;
    bit model_on = 1'b0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .MDOp(MDOp),
        .In0(In0), .In1(In1), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining busy cycles, a pending 64-bit result, architectural HI/LO.
    int          m_left = 0;
    logic [63:0] m_pend = 64'd0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    function automatic logic [63:0] arith(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            4'd1:  return 64'(sa * sb);
            4'd2:  return ua * ub;
            4'd3:  return (b == 0) ? acc : {32'(sa % sb), 32'(sa / sb)};
            4'd4:  return (b == 0) ? acc : {32'(ua % ub), 32'(ua / ub)};
            4'd7:  return acc + 64'(sa * sb);
            4'd8:  return acc + ua * ub;
            4'd9:  return acc - 64'(sa * sb);
            default: return acc - ua * ub;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_pend = 64'd0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else if (m_left > 0) begin
            if (Start) begin
                ill_cnt++;
                $display("[TB] assertion: Start while Busy (op %0d) ignored", MDOp);
            end
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_pend;
        end else if (Start) begin
            case (MDOp)
                4'd1, 4'd2: begin m_pend = arith(MDOp, In0, In1, {m_hi, m_lo}); m_left = 5; end
                4'd3, 4'd4: begin m_pend = arith(MDOp, In0, In1, {m_hi, m_lo}); m_left = 10; end
                4'd5: m_hi = In0;
                4'd6: m_lo = In0;
`ifdef MDU_MADD_EN
                4'd7, 4'd8, 4'd9, 4'd10: begin
                    m_pend = arith(MDOp, In0, In1, {m_hi, m_lo});
                    m_left = 5;
                end
`endif
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("cyc_busy", {31'd0, Busy}, {31'd0, m_left > 0});
            check("cyc_hi", HI, m_hi);
            check("cyc_lo", LO, m_lo);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        Start = 1'b1; MDOp = op; In0 = a; In1 = b;
        @(posedge clk); #1;
        Start = 1'b0; MDOp = 4'd0;
        $display("[TB] issue op=%0d In0=%h In1=%h", op, a, b);
    endtask

    // Counts Busy-high cycles from 1ns after the Start edge until Busy falls.
    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 100) begin
            fails++; tests++;
            $display("[TB] FAIL timeout: Busy stuck high after %0d cycles, required release", n);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, a, b);
        wait_idle(n);
        check({name, "_cycles"}, 32'(n), 32'(exp_cyc));
        check({name, "_hi"}, HI, exp_hi);
        check({name, "_lo"}, LO, exp_lo);
        $display("[TB] %s: cycles=%0d HI=%h LO=%h", name, n, HI, LO);
    endtask

    initial begin
        int n;
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_on = 1'b1;

        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // Divide by zero keeps HI/LO; then a single-cycle mthi.
        issue(4'd5, 32'h11, 32'd0);
        issue(4'd6, 32'h22, 32'd0);
        check("mtlo_busy", {31'd0, Busy}, 32'd0);
        run_op("div0", 4'd3, 32'd1234, 32'd0, 10, 32'h11, 32'h22);
        issue(4'd5, 32'hABCD, 32'd0);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        check("mthi_hi", HI, 32'hABCD);
        check("mthi_lo", LO, 32'h22);

        // mtlo during Busy is ignored; operand changes after Start do not matter.
        issue(4'd1, 32'd3, 32'd4);
        Start = 1'b1; MDOp = 4'd6; In0 = 32'h55;
        @(posedge clk); #1;
        Start = 1'b0; MDOp = 4'd0; In0 = 32'd9;
        wait_idle(n);
        check("mult34_hi", HI, 32'd0);
        check("mult34_lo", LO, 32'd12);
        check("illegal_start_seen", 32'(ill_cnt), 32'd1);
        $display("[TB] mult 3*4 with mtlo in Busy: HI=%h LO=%h", HI, LO);

        // Async reset in the 3rd Busy cycle cancels the divide.
        issue(4'd4, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, Busy}, 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);
        $display("[TB] divu cancelled by reset: HI=%h LO=%h", HI, LO);

        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_MADD_EN
        run_op("madd", 4'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
        run_op("madd_off", 4'd7, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF);
`endif
        // Back-to-back: a new op in the first cycle Busy is low.
        issue(4'd2, 32'h0001_0000, 32'h0001_0000);
        wait_idle(n);
        run_op("b2b_divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage, beside the ALU; takes the same forwarded operands (In0 = rs, In1 = rt).
- Executes mult/multu/div/divu with multi-cycle latency and mthi/mtlo in one cycle.
- Holds the architectural HI/LO registers and drives Busy to the hazard unit.
- The EX result mux selects HI/LO for mfhi/mflo.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (and madd family when enabled)
DIV_CYCLES, 10, cycles Busy stays high for div/divu

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
Start  input  1  qualifies MDOp this cycle (EX instruction is an MDU op, not flushed)
MDOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu
In0  input  32  rs operand
In1  input  32  rt operand
Busy  output  1  multi-cycle operation in progress
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
Interface:
- Single clock clk; reset rst_n is asynchronous, active-low.
- rst_n low: HI=0, LO=0, Busy=0, counter=0, pending results=0, immediately and regardless of clk.

States: IDLE, RUN.

IDLE:
- Start=1 with MDOp 1-4 (or 7-10 when enabled): latch the computed 64-bit result into pending {PH,PL}, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
- Start=1 with mthi: HI<=In0 at that edge. mtlo: LO<=In0. Busy stays 0.
- MDOp 0, codes 11-15, Start=0, or disabled madd codes: no effect.

RUN:
- Busy=1 for exactly N cycles after the Start edge.
- Counter decrements each edge. At the edge where it reaches 0: commit {HI,LO}<={PH,PL}, Busy<=0, return to IDLE.
- New values are visible in the first cycle Busy=0.
- Start in RUN is ignored for every MDOp, including mthi/mtlo. The hazard unit stalls using Busy|Start, so this condition is illegal upstream; the bench flags it as an assertion.

Arithmetic:
- mult: signed 32x32 -> 64; HI=upper, LO=lower.
- multu: unsigned 32x32 -> 64.
- div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend (In0).
- divu: unsigned quotient/remainder.
- Divide by zero (In1=0): Busy still runs DIV_CYCLES; HI/LO unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no trap.
- Operands are sampled only at the Start edge; later changes to In0/In1 do not affect the result.

Simultaneous events:
- Async reset during RUN cancels the operation; no later commit.
- Start of the next op can be accepted in the cycle after Busy falls. That is the same cycle the committed HI/LO are visible, so madd reads the committed values.

Optional Feature:
MDU_MADD_EN.
- Defined: MDOp 7 madd ({HI,LO} + signed product), 8 maddu (+ unsigned product), 9 msub (- signed product), 10 msubu (- unsigned product).
- All are mod 2^64, use MULT_CYCLES latency, and use {HI,LO} as sampled at the Start edge.
- Undefined: codes 7-10 are no-ops, with Busy unaffected and HI/LO unchanged.

Test Plan:
1. Start mult, In0=0xFFFFFFFF, In1=2 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat as multu -> HI=0x00000001, LO=0xFFFFFFFE.
2. Start div, In0=0xFFFFFFF9 (-7), In1=2 -> Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
3. With HI=0x11, LO=0x22: div In1=0 -> Busy 10 cycles, then HI=0x11, LO=0x22. Then mthi In0=0xABCD -> HI=0xABCD next cycle, Busy stays 0.
4. Start mult 3*4, then Start mtlo In0=0x55 in the 2nd Busy cycle (assertion fires) -> mtlo ignored; after commit LO=12, HI=0. In0 changed to 9 during Busy -> result still 12.
5. Start divu 100/7, pull rst_n low in the 3rd Busy cycle -> Busy, HI and LO are 0 at once; after rst_n release they stay 0 with no commit.
6. MDU_MADD_EN defined, HI=0, LO=0xFFFFFFFF: madd In0=1, In1=1 -> after 5 cycles HI=1, LO=0. Same stimulus without the macro -> Busy stays 0 and HI/LO unchanged.
